// File: rtl/uart_rx_core.sv
// 16x-oversampled UART receiver: start, DATA_WIDTH data bits LSB-first, optional even parity, stop.
// Define UART_RX_MAJORITY_EN for a 3-sample majority vote per bit; the default is a single mid-bit sample.
module uart_rx_core #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PARITY_EN  = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_baud_x16,
    input  logic                  i_RX,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic                  o_valid,
    output logic [1:0]            o_error
);

    localparam int unsigned        BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] StartTick = 4'd8;
`else
    localparam logic [3:0] StartTick = 4'd7;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitHigh
    } state_e;

    state_e                  state_q;
    logic [3:0]              tick_cnt_q;
    logic [BitCntW-1:0]      bit_cnt_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic                    par_err_q;
    logic                    rx_meta_q;
    logic                    rx_sync_q;
    logic [3:0]              decide_tick;
    logic                    decide;
    logic                    bit_val;

    // Line idles high, so the synchronizer resets high to avoid a false start after reset.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= i_RX;
            rx_sync_q <= rx_meta_q;
        end
    end

    // START decides mid-bit; later bits decide one full bit time after the previous decision.
    assign decide_tick = (state_q == StStart) ? StartTick : 4'd15;
    assign decide      = i_baud_x16 && (tick_cnt_q == decide_tick);

`ifdef UART_RX_MAJORITY_EN
    logic vote_a_q;
    logic vote_b_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            vote_a_q <= 1'b1;
            vote_b_q <= 1'b1;
        end else if (i_baud_x16) begin
            if (tick_cnt_q == decide_tick - 4'd2) vote_a_q <= rx_sync_q;
            if (tick_cnt_q == decide_tick - 4'd1) vote_b_q <= rx_sync_q;
        end
    end

    assign bit_val = (vote_a_q & vote_b_q) | (vote_a_q & rx_sync_q) | (vote_b_q & rx_sync_q);
`else
    assign bit_val = rx_sync_q;
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            o_dout     <= '0;
            o_valid    <= 1'b0;
            o_error    <= 2'b00;
        end else begin
            o_valid <= 1'b0;
            if (i_baud_x16) begin
                unique case (state_q)
                    StIdle: begin
                        if (!rx_sync_q) begin
                            state_q    <= StStart;
                            tick_cnt_q <= '0;
                        end
                    end
                    StStart: begin
                        if (decide) begin
                            if (bit_val) begin
                                state_q <= StIdle;
                            end else begin
                                state_q    <= StData;
                                tick_cnt_q <= '0;
                                bit_cnt_q  <= '0;
                                par_err_q  <= 1'b0;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 4'd1;
                        end
                    end
                    StData: begin
                        tick_cnt_q <= tick_cnt_q + 4'd1;
                        if (decide) begin
                            shift_q[bit_cnt_q] <= bit_val;
                            if (bit_cnt_q == LastBit) begin
                                state_q <= (PARITY_EN != 0) ? StParity : StStop;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                    end
                    StParity: begin
                        tick_cnt_q <= tick_cnt_q + 4'd1;
                        if (decide) begin
                            par_err_q <= (bit_val != ^shift_q);
                            state_q   <= StStop;
                        end
                    end
                    StStop: begin
                        tick_cnt_q <= tick_cnt_q + 4'd1;
                        if (decide) begin
                            o_dout  <= shift_q;
                            o_error <= {par_err_q, ~bit_val};
                            o_valid <= 1'b1;
                            state_q <= bit_val ? StIdle : StWaitHigh;
                        end
                    end
                    StWaitHigh: begin
                        if (rx_sync_q) state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomized bench for uart_rx_core: two receivers (no parity / even parity) fed by a serial-frame
// model; each frame's expected word and error flags are derived directly from what was sent.
`timescale 1ns/1ps
module tb_uart_rx_core;

    logic       clk    = 1'b0;
    logic       rstn   = 1'b0;
    logic       baud   = 1'b0;
    logic       rx0    = 1'b1;
    logic       rx1    = 1'b1;
    logic [7:0] dout0;
    logic [7:0] dout1;
    logic       valid0;
    logic       valid1;
    logic [1:0] err0;
    logic [1:0] err1;

    int checks   = 0;
    int failures = 0;
    int baud_div = 4;
    int bcnt     = 0;

    logic [9:0] got0[$];
    logic [9:0] got1[$];

    uart_rx_core #(.DATA_WIDTH(8), .PARITY_EN(0)) u_dut0 (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_baud_x16 (baud),
        .i_RX       (rx0),
        .o_dout     (dout0),
        .o_valid    (valid0),
        .o_error    (err0)
    );

    uart_rx_core #(.DATA_WIDTH(8), .PARITY_EN(1)) u_dut1 (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_baud_x16 (baud),
        .i_RX       (rx1),
        .o_dout     (dout1),
        .o_valid    (valid1),
        .o_error    (err1)
    );

    always #5 clk = ~clk;

    // 16x tick: one clk wide every baud_div clocks (continuous high when baud_div is 1).
    always @(negedge clk) begin
        if (bcnt >= baud_div - 1) begin
            baud = 1'b1;
            bcnt = 0;
        end else begin
            baud = 1'b0;
            bcnt++;
        end
    end

    always @(negedge clk) begin
        if (valid0) got0.push_back({err0, dout0});
        if (valid1) got1.push_back({err1, dout1});
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_line(input bit which, input logic v);
        if (which) rx1 = v;
        else       rx0 = v;
    endtask

    task automatic hold_bits(input int n);
        repeat (n * 16 * baud_div) @(negedge clk);
    endtask

    task automatic send_frame(input bit which, input logic [7:0] d, input bit par_flip,
                              input bit stop_low, input int gap_clks);
        logic [9:0] e;
        logic [1:0] exp_err;
        int         n;
        int         other;
        set_line(which, 1'b0);
        hold_bits(1);
        for (int i = 0; i < 8; i++) begin
            set_line(which, d[i]);
            hold_bits(1);
        end
        if (which) begin
            set_line(which, (^d) ^ par_flip);
            hold_bits(1);
        end
        if (stop_low) begin
            set_line(which, 1'b0);
            hold_bits(2);
        end else begin
            set_line(which, 1'b1);
            hold_bits(1);
        end
        set_line(which, 1'b1);
        exp_err = {which & par_flip, stop_low};
        n       = which ? got1.size() : got0.size();
        other   = which ? got0.size() : got1.size();
        check_eq("valid_count", n, 1);
        check_eq("other_quiet", other, 0);
        if (n > 0) begin
            e = which ? got1.pop_front() : got0.pop_front();
            check_eq("dout", {24'd0, e[7:0]}, {24'd0, d});
            check_eq("error", {30'd0, e[9:8]}, {30'd0, exp_err});
        end
        check_eq("held", which ? {22'd0, err1, dout1} : {22'd0, err0, dout0},
                 {22'd0, exp_err, d});
        got0.delete();
        got1.delete();
        repeat (gap_clks) @(negedge clk);
    endtask

    initial begin
        logic [7:0] d;
        bit         which;
        bit         flip;
        bit         slow;
        int         gap;

        repeat (4) @(negedge clk);
        check_eq("rst_dout0", {24'd0, dout0}, 32'd0);
        check_eq("rst_err0", {30'd0, err0}, 32'd0);
        check_eq("rst_valid0", {31'd0, valid0}, 32'd0);
        check_eq("rst_dout1", {24'd0, dout1}, 32'd0);
        rstn = 1'b1;
        hold_bits(2);

        send_frame(1'b0, 8'hA6, 1'b0, 1'b0, 16 * baud_div);
        send_frame(1'b0, 8'h37, 1'b0, 1'b0, 0);
        send_frame(1'b0, 8'h00, 1'b0, 1'b0, 16 * baud_div);
        send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 16 * baud_div);

        // Short low glitch must be rejected as a false start.
        set_line(1'b0, 1'b0);
        repeat (4 * baud_div) @(negedge clk);
        set_line(1'b0, 1'b1);
        hold_bits(2);
        check_eq("glitch_no_valid", got0.size(), 0);
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 16 * baud_div);

        send_frame(1'b0, 8'h3C, 1'b0, 1'b1, 16 * baud_div);
        send_frame(1'b0, 8'h12, 1'b0, 1'b0, 16 * baud_div);

        send_frame(1'b1, 8'h37, 1'b0, 1'b0, 16 * baud_div);
        send_frame(1'b1, 8'h37, 1'b1, 1'b0, 16 * baud_div);
        send_frame(1'b1, 8'hC9, 1'b0, 1'b1, 16 * baud_div);

        for (int k = 0; k < 14; k++) begin
            baud_div = $urandom_range(1, 4);
            hold_bits(1);
            which = 1'($urandom_range(0, 1));
            d     = 8'($urandom);
            flip  = 1'($urandom_range(0, 1));
            slow  = ($urandom_range(0, 5) == 0);
            gap   = $urandom_range(0, 32 * baud_div);
            if (slow) gap = gap + 16 * baud_div;
            send_frame(which, d, flip, slow, gap);
        end

        baud_div = 3;
        hold_bits(1);
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 16 * baud_div);
        send_frame(1'b1, 8'hA5, 1'b0, 1'b0, 16 * baud_div);

        // Reset in the middle of a frame on the no-parity receiver.
        set_line(1'b0, 1'b0);
        hold_bits(1);
        set_line(1'b0, 1'b1);
        hold_bits(2);
        set_line(1'b0, 1'b0);
        hold_bits(1);
        rstn = 1'b0;
        rx0  = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("midrst_dout0", {24'd0, dout0}, 32'd0);
        check_eq("midrst_err0", {30'd0, err0}, 32'd0);
        check_eq("midrst_valid0", {31'd0, valid0}, 32'd0);
        check_eq("midrst_dout1", {24'd0, dout1}, 32'd0);
        rstn = 1'b1;
        hold_bits(12);
        check_eq("midrst_no_valid", got0.size() + got1.size(), 0);
        send_frame(1'b0, 8'h6B, 1'b0, 1'b0, 16 * baud_div);
        send_frame(1'b1, 8'h94, 1'b1, 1'b0, 16 * baud_div);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
